// File: rtl/seq_mul_rv.sv
// rtl/seq_mul_rv.sv - multi-mode sequential shift-add multiplier (MUL/MULH/MULHSU/MULHU) with valid/ready
module seq_mul_rv #(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t               state, state_nxt;
    logic [1:0]           mode_q;
    logic                 neg_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [2*WIDTH:0]     acc_q;
    logic [CNT_W-1:0]     cnt_q;

    logic                 a_signed, b_signed;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   mag, prod_fix;

    assign a_signed = (mode == 2'b01) || (mode == 2'b10);
    assign b_signed = (mode == 2'b01);
    // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is still correct unsigned
    assign a_mag    = (a_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_mag    = (b_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

    assign sum      = acc_q[2*WIDTH:WIDTH] + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    assign mag      = acc_q[2*WIDTH-1:0];
    assign prod_fix = neg_q ? (~mag + 1'b1) : mag;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = CALC;
            CALC:    if (cnt_q == CNT_W'(WIDTH - 1)) state_nxt = FIXUP;
            FIXUP:   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            mode_q   <= 2'b00;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result   <= '0;
            product  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mode_q   <= mode;
                        neg_q    <= (a_signed & a[WIDTH-1]) ^ (b_signed & b[WIDTH-1]);
                        mcand_q  <= a_mag;
                        mplier_q <= b_mag;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                CALC: begin
                    // Add into the upper WIDTH+1 bits, then shift the whole accumulator right
                    acc_q    <= {1'b0, sum, acc_q[WIDTH-1:1]};
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                end
                FIXUP: begin
                    product <= prod_fix;
                    result  <= (mode_q == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul_rv.sv
// tb/tb_seq_mul_rv.sv - self-checking bench for seq_mul_rv at WIDTH=8 and WIDTH=64
module tb_seq_mul_rv;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;
    logic Rst;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [1:0]  mode8;
    logic [7:0]  a8, b8, result8;
    logic [15:0] product8;

    logic         in_valid64, in_ready64, out_valid64, out_ready64;
    logic [1:0]   mode64;
    logic [63:0]  a64, b64, result64;
    logic [127:0] product64;

    int checks = 0;
    int errors = 0;

    seq_mul_rv #(.WIDTH(8)) dut8 (
        .Clk(Clk), .Rst(Rst), .in_valid(in_valid8), .in_ready(in_ready8), .mode(mode8),
        .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .product(product8)
    );

    seq_mul_rv #(.WIDTH(64)) dut64 (
        .Clk(Clk), .Rst(Rst), .in_valid(in_valid64), .in_ready(in_ready64), .mode(mode64),
        .a(a64), .b(b64), .out_valid(out_valid64), .out_ready(out_ready64),
        .result(result64), .product(product64)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sign-extend to 128 bits where the mode says so, multiply, keep 2*w bits
    function automatic logic [127:0] ref_product(input int w, input logic [1:0] m,
                                                 input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ea, eb, p, one;
        one = 128'd1;
        ea  = {64'd0, a};
        eb  = {64'd0, b};
        if ((m == 2'b01 || m == 2'b10) && a[w-1]) ea = ea - (one << w);
        if (m == 2'b01 && b[w-1]) eb = eb - (one << w);
        p = ea * eb;
        if (w < 64) p = p & ((one << (2 * w)) - one);
        return p;
    endfunction

    function automatic logic [63:0] ref_result(input int w, input logic [1:0] m, input logic [127:0] p);
        logic [127:0] s, one;
        one = 128'd1;
        s   = (m == 2'b00) ? p : (p >> w);
        if (w < 64) s = s & ((one << w) - one);
        return s[63:0];
    endfunction

    task automatic op8(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp_p, input logic [7:0] exp_r, input int hold, input string tag);
        int k;
        @(negedge Clk);
        chk($sformatf("%s/in_ready_idle", tag), 128'(in_ready8), 128'd1);
        mode8 = m; a8 = a; b8 = b; in_valid8 = 1'b1;
        @(negedge Clk);
        in_valid8 = 1'b0;
        k = 0;
        while (!out_valid8 && k < 40) begin
            mode8 = 2'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
            in_valid8 = 1'($urandom); out_ready8 = 1'($urandom);
            @(negedge Clk);
            k++;
        end
        in_valid8 = 1'b0; out_ready8 = 1'b0;
        chk($sformatf("%s/latency", tag), 128'(k), 128'd9);
        chk($sformatf("%s/product", tag), 128'(product8), 128'(exp_p));
        chk($sformatf("%s/result", tag), 128'(result8), 128'(exp_r));
        for (int i = 0; i < hold; i++) begin
            @(negedge Clk);
            chk($sformatf("%s/hold_result%0d", tag, i), 128'(result8), 128'(exp_r));
            chk($sformatf("%s/hold_valid%0d", tag, i), 128'(out_valid8), 128'd1);
            chk($sformatf("%s/hold_in_ready%0d", tag, i), 128'(in_ready8), 128'd0);
        end
        out_ready8 = 1'b1;
        @(negedge Clk);
        out_ready8 = 1'b0;
        chk($sformatf("%s/in_ready_after", tag), 128'(in_ready8), 128'd1);
        chk($sformatf("%s/out_valid_after", tag), 128'(out_valid8), 128'd0);
        chk($sformatf("%s/result_kept", tag), 128'(result8), 128'(exp_r));
    endtask

    task automatic op64(input logic [1:0] m, input logic [63:0] a, input logic [63:0] b, input string tag);
        int k;
        logic [127:0] ep;
        ep = ref_product(64, m, a, b);
        @(negedge Clk);
        mode64 = m; a64 = a; b64 = b; in_valid64 = 1'b1;
        @(negedge Clk);
        in_valid64 = 1'b0;
        k = 0;
        while (!out_valid64 && k < 100) begin
            a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; mode64 = 2'($urandom);
            @(negedge Clk);
            k++;
        end
        if (k != 65) chk($sformatf("%s/latency", tag), 128'(k), 128'd65);
        chk($sformatf("%s/product", tag), product64, ep);
        chk($sformatf("%s/result", tag), 128'(result64), 128'(ref_result(64, m, ep)));
        out_ready64 = 1'b1;
        @(negedge Clk);
        out_ready64 = 1'b0;
    endtask

    initial begin
        logic [1:0]   rm;
        logic [7:0]   ra, rb;
        logic [127:0] rp;
        Rst = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; mode8 = 2'b00; a8 = '0; b8 = '0;
        in_valid64 = 1'b0; out_ready64 = 1'b0; mode64 = 2'b00; a64 = '0; b64 = '0;
        #1;
        chk("reset/in_ready", 128'(in_ready8), 128'd1);
        chk("reset/out_valid", 128'(out_valid8), 128'd0);
        chk("reset/product", 128'(product8), 128'd0);
        chk("reset/result", 128'(result8), 128'd0);
        repeat (2) @(negedge Clk);
        Rst = 1'b1;

        op8(2'b11, 8'hFF, 8'hFF, 16'hFE01, 8'hFE, 0, "mulhu_ff_ff");
        op8(2'b01, 8'h80, 8'h80, 16'h4000, 8'h40, 5, "mulh_80_80");
        op8(2'b00, 8'hFF, 8'hFF, 16'hFE01, 8'h01, 0, "mul_ff_ff");
        op8(2'b10, 8'hFF, 8'hFF, 16'hFF01, 8'hFF, 0, "mulhsu_ff_ff");
        op8(2'b01, 8'h00, 8'h85, 16'h0000, 8'h00, 0, "mulh_zero_neg");
        op8(2'b10, 8'h80, 8'hFF, 16'h8080, 8'h80, 0, "mulhsu_80_ff");

        // Asynchronous reset in the middle of CALC
        @(negedge Clk);
        mode8 = 2'b11; a8 = 8'hAB; b8 = 8'hCD; in_valid8 = 1'b1;
        @(negedge Clk);
        in_valid8 = 1'b0;
        repeat (3) @(negedge Clk);
        #2 Rst = 1'b0;
        #1;
        chk("midrst/out_valid", 128'(out_valid8), 128'd0);
        chk("midrst/in_ready", 128'(in_ready8), 128'd1);
        chk("midrst/product", 128'(product8), 128'd0);
        @(negedge Clk);
        Rst = 1'b1;
        op8(2'b11, 8'h03, 8'h05, 16'h000F, 8'h00, 0, "after_rst");

        for (int i = 0; i < 24; i++) begin
            rm = 2'($urandom); ra = 8'($urandom); rb = 8'($urandom);
            rp = ref_product(8, rm, {56'd0, ra}, {56'd0, rb});
            op8(rm, ra, rb, rp[15:0], 8'(ref_result(8, rm, rp)), 0, $sformatf("rand8_%0d", i));
        end

        op64(2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, "w64_mulh_min_min");
        chk("w64_min_min_const", product64, 128'h4000_0000_0000_0000_0000_0000_0000_0000);
        for (int i = 0; i < 1000; i++) begin
            op64(2'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, $sformatf("rand64_%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
